// File: rtl/noc_mesh_router.sv
// noc_mesh_router: 5-port wormhole mesh router (0=N 1=S 2=W 3=E 4=L).
// Each input has a FIFO and a YX route decoder. Each output has a round-robin
// arbiter that locks to one packet, plus a downstream credit counter.
// Optional feature macro NOC_ROUTER_DROP_EN: when it is defined, a packet whose
// head routes to a disabled output is popped and discarded. When it is
// undefined, such a head blocks its input.
// Handshake: valid_i writes one flit per cycle. Upstream may send only while
// it holds a credit, and credit_o returns one credit for each flit popped.
// Downstream returns one credit_i pulse for each flit it consumes, and an
// output sends only while its credit counter is non-zero.
module noc_mesh_router #(
  parameter int          DATA_W    = 16,
  parameter int          COORD_W   = 4,
  parameter int          BUF_DEPTH = 8,
  parameter logic [4:0]  PORT_EN   = 5'b11111,
  localparam int         CW        = $clog2(BUF_DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [2*COORD_W-1:0]   yx_addr_router_i,
  input  logic [5*DATA_W-1:0]    data_i,
  input  logic [4:0]             valid_i,
  input  logic [4:0]             credit_i,
  output logic [5*DATA_W-1:0]    data_o,
  output logic [4:0]             valid_o,
  output logic [4:0]             credit_o,
  output logic                   err_o,
  output logic [4:0]             dbg_arb_locked_o,
  output logic [5*CW-1:0]        dbg_credit_o
);
  localparam int AW = $clog2(BUF_DEPTH);
  localparam logic [CW-1:0] CRED_MAX = CW'(BUF_DEPTH);
  localparam logic [AW:0]   PTR_ONE  = (AW+1)'(1);
  localparam logic ARB_IDLE   = 1'b0;
  localparam logic ARB_LOCKED = 1'b1;
  localparam logic [2:0] P_N = 3'd0, P_S = 3'd1, P_W = 3'd2, P_E = 3'd3, P_L = 3'd4;

  logic [DATA_W-1:0]       mem_q [5][BUF_DEPTH];
  logic [4:0][AW:0]        wr_ptr_q, wr_vis_q, rd_ptr_q;
  logic [4:0][2:0]         route_q;
  logic [4:0]              drop_q;
  logic [4:0][CW-1:0]      cred_q, cred_d;
  logic [4:0]              arb_st_q, arb_st_d;
  logic [4:0][2:0]         arb_own_q, arb_own_d, rr_q, rr_d;
  logic [4:0][DATA_W-1:0]  data_q, data_d;
  logic [4:0]              valid_q, valid_d, credo_q;
  logic                    err_q;

  logic [4:0]              empty, full, is_head, is_tail, misroute;
  logic [4:0]              wr_en, fwd_pop, drop_pop, pop;
  logic [4:0][DATA_W-1:0]  front;
  logic [4:0][2:0]         route_f;
  logic [4:0]              gnt_vld;
  logic [4:0][2:0]         gnt_src;
  logic [2:0]              rr_idx;

  function automatic logic [2:0] yx_route(input logic [DATA_W-1:0] f,
                                          input logic [2*COORD_W-1:0] me);
    logic [COORD_W-1:0] dy, dx, ry, rx;
    dy = f[2*COORD_W-1:COORD_W];
    dx = f[COORD_W-1:0];
    ry = me[2*COORD_W-1:COORD_W];
    rx = me[COORD_W-1:0];
    if (dy < ry)      return P_N;
    else if (dy > ry) return P_S;
    else if (dx < rx) return P_W;
    else if (dx > rx) return P_E;
    else              return P_L;
  endfunction

  function automatic logic [2:0] rr_next(input logic [2:0] p, input logic [2:0] k);
    logic [3:0] s;
    s = {1'b0, p} + {1'b0, k};
    return (s >= 4'd5) ? 3'(s - 4'd5) : s[2:0];
  endfunction

  // Decode each FIFO front. The read side sees writes one cycle late, which
  // gives the two-edge input-to-output latency.
  always_comb begin
    for (int i = 0; i < 5; i++) begin
      empty[i]    = (rd_ptr_q[i] == wr_vis_q[i]);
      full[i]     = (wr_ptr_q[i] == {~rd_ptr_q[i][AW], rd_ptr_q[i][AW-1:0]});
      front[i]    = mem_q[i][rd_ptr_q[i][AW-1:0]];
      is_head[i]  = front[i][DATA_W-1];
      is_tail[i]  = front[i][DATA_W-2];
      route_f[i]  = is_head[i] ? yx_route(front[i], yx_addr_router_i) : route_q[i];
      misroute[i] = PORT_EN[i] & ~empty[i] & is_head[i] & ~drop_q[i] & ~PORT_EN[route_f[i]];
`ifdef NOC_ROUTER_DROP_EN
      drop_pop[i] = PORT_EN[i] & ~empty[i] & (misroute[i] | drop_q[i]);
`else
      drop_pop[i] = 1'b0;
`endif
    end
  end

  // Per-output arbitration, lock tracking and credit counting.
  always_comb begin
    gnt_vld   = '0;
    gnt_src   = '0;
    arb_st_d  = arb_st_q;
    arb_own_d = arb_own_q;
    rr_d      = rr_q;
    cred_d    = cred_q;
    data_d    = '0;
    valid_d   = '0;
    fwd_pop   = '0;
    rr_idx    = '0;
    for (int o = 0; o < 5; o++) begin
      if (PORT_EN[o] && cred_q[o] != '0) begin
        if (arb_st_q[o] == ARB_LOCKED) begin
          if (!empty[arb_own_q[o]]) begin
            gnt_vld[o] = 1'b1;
            gnt_src[o] = arb_own_q[o];
          end
        end else begin
          for (int k = 1; k <= 5; k++) begin
            rr_idx = rr_next(rr_q[o], k[2:0]);
            if (!gnt_vld[o] && !empty[rr_idx] && is_head[rr_idx] &&
                route_f[rr_idx] == o[2:0]) begin
              gnt_vld[o] = 1'b1;
              gnt_src[o] = rr_idx;
            end
          end
        end
      end
      if (gnt_vld[o]) begin
        fwd_pop[gnt_src[o]] = 1'b1;
        data_d[o]  = front[gnt_src[o]];
        valid_d[o] = 1'b1;
        if (arb_st_q[o] == ARB_IDLE) begin
          rr_d[o] = gnt_src[o];
          if (!is_tail[gnt_src[o]]) begin
            arb_st_d[o]  = ARB_LOCKED;
            arb_own_d[o] = gnt_src[o];
          end
        end else if (is_tail[gnt_src[o]]) begin
          arb_st_d[o] = ARB_IDLE;
        end
      end
      case ({gnt_vld[o], credit_i[o] & PORT_EN[o]})
        2'b10:   cred_d[o] = cred_q[o] - CW'(1);
        2'b01:   cred_d[o] = (cred_q[o] == CRED_MAX) ? cred_q[o] : cred_q[o] + CW'(1);
        default: cred_d[o] = cred_q[o];
      endcase
    end
    pop   = fwd_pop | drop_pop;
    wr_en = PORT_EN & valid_i & (~full | pop);
  end

  // FIFO storage carries no reset; the pointers define which entries are valid.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 5; i++)
      if (wr_en[i]) mem_q[i][wr_ptr_q[i][AW-1:0]] <= data_i[i*DATA_W +: DATA_W];
  end

  // Pointers, route latches, arbiter state, credits and the registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q  <= '0;
      wr_vis_q  <= '0;
      rd_ptr_q  <= '0;
      route_q   <= '0;
      drop_q    <= '0;
      cred_q    <= {5{CRED_MAX}};
      arb_st_q  <= {5{ARB_IDLE}};
      arb_own_q <= '0;
      rr_q      <= '0;
      data_q    <= '0;
      valid_q   <= '0;
      credo_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      for (int i = 0; i < 5; i++) begin
        if (wr_en[i]) wr_ptr_q[i] <= wr_ptr_q[i] + PTR_ONE;
        wr_vis_q[i] <= wr_ptr_q[i];
        if (pop[i]) rd_ptr_q[i] <= rd_ptr_q[i] + PTR_ONE;
        if (fwd_pop[i] && is_head[i]) route_q[i] <= route_f[i];
        if (drop_pop[i]) drop_q[i] <= ~is_tail[i];
      end
      cred_q    <= cred_d;
      arb_st_q  <= arb_st_d;
      arb_own_q <= arb_own_d;
      rr_q      <= rr_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      credo_q   <= pop;
      err_q     <= err_q | (|misroute);
    end
  end

  assign data_o           = data_q;
  assign valid_o          = valid_q;
  assign credit_o         = credo_q;
  assign err_o            = err_q;
  assign dbg_arb_locked_o = arb_st_q;
  assign dbg_credit_o     = cred_q;
endmodule

// File: tb/tb_noc_mesh_router.sv
// Bench for noc_mesh_router: a full 5-port router and an NW-corner router,
// both at address (2,2), checked through per-output expected queues.
module tb_noc_mesh_router;
  localparam int DW = 16;
  localparam logic [19:0] CRED_FULL = {5{4'd8}};

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [79:0] d1_data_i, d2_data_i, d1_data_o, d2_data_o;
  logic [4:0]  d1_valid_i, d2_valid_i, d1_valid_o, d2_valid_o;
  logic [4:0]  d1_cr_auto, d1_cr_man, d2_cr_auto, d2_cr_man;
  logic [4:0]  d1_credit_o, d2_credit_o, d1_lock, d2_lock;
  logic [4:0]  auto_mask1, auto_mask2;
  logic        d1_err, d2_err;
  logic [19:0] d1_cred, d2_cred;
  wire  [4:0]  d1_credit_i = d1_cr_auto | d1_cr_man;
  wire  [4:0]  d2_credit_i = d2_cr_auto | d2_cr_man;
  wire  [7:0]  my_addr = {4'd2, 4'd2};

  noc_mesh_router #(.PORT_EN(5'b11111)) dut (
    .clk(clk), .reset(reset), .yx_addr_router_i(my_addr),
    .data_i(d1_data_i), .valid_i(d1_valid_i), .credit_i(d1_credit_i),
    .data_o(d1_data_o), .valid_o(d1_valid_o), .credit_o(d1_credit_o),
    .err_o(d1_err), .dbg_arb_locked_o(d1_lock), .dbg_credit_o(d1_cred));

  noc_mesh_router #(.PORT_EN(5'b11010)) dut_c (
    .clk(clk), .reset(reset), .yx_addr_router_i(my_addr),
    .data_i(d2_data_i), .valid_i(d2_valid_i), .credit_i(d2_credit_i),
    .data_o(d2_data_o), .valid_o(d2_valid_o), .credit_o(d2_credit_o),
    .err_o(d2_err), .dbg_arb_locked_o(d2_lock), .dbg_credit_o(d2_cred));

  // Scoreboard: index d*5+p holds the flits expected on output p of dut d.
  logic [DW-1:0] exp_q [10][$];
  int checks = 0;
  int errors = 0;
  int seen [10];
  int run_len [10];
  int max_run [10];
  int crd_cnt [10];
  logic          mon_v, mon_c;
  logic [DW-1:0] mon_dat, mon_e;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: pop and compare whenever an output presents a flit.
  always @(negedge clk) begin
    if (reset) begin
      for (int d = 0; d < 2; d++) begin
        for (int p = 0; p < 5; p++) begin
          mon_v   = (d == 0) ? d1_valid_o[p] : d2_valid_o[p];
          mon_c   = (d == 0) ? d1_credit_o[p] : d2_credit_o[p];
          mon_dat = (d == 0) ? d1_data_o[p*DW +: DW] : d2_data_o[p*DW +: DW];
          if (mon_c) crd_cnt[d*5+p]++;
          if (mon_v) begin
            run_len[d*5+p]++;
            if (run_len[d*5+p] > max_run[d*5+p]) max_run[d*5+p] = run_len[d*5+p];
            seen[d*5+p]++;
            checks++;
            if (exp_q[d*5+p].size() == 0) begin
              errors++;
              $display("FAIL unexpected_flit dut%0d port%0d got %0h expected none", d, p, mon_dat);
            end else begin
              mon_e = exp_q[d*5+p].pop_front();
              if (mon_dat !== mon_e) begin
                errors++;
                $display("FAIL flit_data dut%0d port%0d got %0h expected %0h", d, p, mon_dat, mon_e);
              end
            end
          end else begin
            run_len[d*5+p] = 0;
          end
        end
      end
    end
  end

  // Downstream model: return one credit the cycle after each flit when enabled.
  initial begin
    d1_cr_auto = '0;
    d2_cr_auto = '0;
    forever begin
      @(posedge clk); #1;
      d1_cr_auto = d1_valid_o & auto_mask1;
      d2_cr_auto = d2_valid_o & auto_mask2;
    end
  end

  function automatic logic [DW-1:0] mk(input logic h, input logic t, input logic [3:0] dy,
                                       input logic [3:0] dx, input logic [5:0] tag);
    return {h, t, tag, dy, dx};
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic clr_in();
    d1_valid_i = '0; d2_valid_i = '0; d1_data_i = '0; d2_data_i = '0;
  endtask

  task automatic put(input int d, input int p, input logic [DW-1:0] f);
    if (d == 0) begin
      d1_valid_i[p] = 1'b1; d1_data_i[p*DW +: DW] = f;
    end else begin
      d2_valid_i[p] = 1'b1; d2_data_i[p*DW +: DW] = f;
    end
  endtask

  logic [DW-1:0] f;
  int s0, c0, c1;

  initial begin
    clr_in();
    d1_cr_man = '0; d2_cr_man = '0;
    auto_mask1 = '0; auto_mask2 = '0;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid_o", {27'b0, d1_valid_o}, 32'h0);
    chk("rst_data_o", {31'b0, |d1_data_o}, 32'h0);
    chk("rst_credit_o", {27'b0, d1_credit_o}, 32'h0);
    chk("rst_err_o", {31'b0, d1_err}, 32'h0);
    chk("rst_credits", {12'b0, d1_cred}, {12'b0, CRED_FULL});
    reset = 1'b1;
    tick();

    // Single flit S -> L, two-edge latency and credit bookkeeping.
    f = mk(1, 1, 4'd2, 4'd2, 6'h01);
    exp_q[4].push_back(f);
    put(0, 1, f);
    tick();                      // edge 0
    clr_in();
    tick();                      // edge 1
    chk("lat_not_early", {31'b0, d1_valid_o[4]}, 32'h0);
    tick();                      // edge 2
    chk("lat_valid_L", {31'b0, d1_valid_o[4]}, 32'h1);
    chk("lat_credit_o_S", {27'b0, d1_credit_o}, 32'h2);
    chk("credit_L_7", {28'b0, d1_cred[16 +: 4]}, 32'h7);
    d1_cr_man[4] = 1'b1;
    tick();
    d1_cr_man[4] = 1'b0;
    chk("credit_L_back_8", {28'b0, d1_cred[16 +: 4]}, 32'h8);
    chk("credit_o_single_pulse", {27'b0, d1_credit_o}, 32'h0);
    auto_mask1 = 5'b11111;
    auto_mask2 = 5'b11111;

    // Contention W and E -> N; round 1 W first, lone W, round 2 E first.
    for (int r = 0; r < 3; r++) begin
      max_run[0] = 0;
      if (r == 1) begin
        f = mk(1, 1, 4'd0, 4'd2, 6'h20);
        exp_q[0].push_back(f);
        put(0, 2, f);
        tick();
        clr_in();
      end else begin
        for (int k = 0; k < 3; k++)
          exp_q[0].push_back(mk(k == 0, k == 2, 4'd0, 4'd2, 6'(r*8 + k)));
        for (int k = 0; k < 3; k++)
          exp_q[0].push_back(mk(k == 0, k == 2, 4'd0, 4'd2, 6'(r*8 + k + 4)));
        if (r == 2) begin
          // E wins this round: move E packet ahead of W packet in expectation.
          for (int k = 0; k < 3; k++) void'(exp_q[0].pop_back());
          for (int k = 0; k < 3; k++) void'(exp_q[0].pop_back());
          for (int k = 0; k < 3; k++)
            exp_q[0].push_back(mk(k == 0, k == 2, 4'd0, 4'd2, 6'(r*8 + k + 4)));
          for (int k = 0; k < 3; k++)
            exp_q[0].push_back(mk(k == 0, k == 2, 4'd0, 4'd2, 6'(r*8 + k)));
        end
        for (int k = 0; k < 3; k++) begin
          clr_in();
          d1_valid_i[2] = 1'b1; d1_data_i[2*DW +: DW] = mk(k == 0, k == 2, 4'd0, 4'd2, 6'(r*8 + k));
          d1_valid_i[3] = 1'b1; d1_data_i[3*DW +: DW] = mk(k == 0, k == 2, 4'd0, 4'd2, 6'(r*8 + k + 4));
          tick();
        end
        clr_in();
      end
      repeat (10) tick();
      chk("contention_drain", exp_q[0].size(), 32'h0);
      if (r != 1) chk("contention_contiguous", max_run[0], 32'd6);
    end

    // Credit stall on E: 10 packets L -> E with no downstream credit.
    auto_mask1[3] = 1'b0;
    s0 = seen[3];
    for (int k = 0; k < 10; k++) begin
      clr_in();
      f = mk(1, 1, 4'd2, 4'd3, 6'(k));
      exp_q[3].push_back(f);
      put(0, 4, f);
      tick();
    end
    clr_in();
    repeat (6) tick();
    chk("stall_sent_8", seen[3] - s0, 32'd8);
    chk("stall_buffered_2", exp_q[3].size(), 32'd2);
    chk("stall_credit_0", {28'b0, d1_cred[12 +: 4]}, 32'h0);
    for (int k = 0; k < 2; k++) begin
      d1_cr_man[3] = 1'b1;
      tick();
      d1_cr_man[3] = 1'b0;
      chk("stall_no_send_on_credit_edge", {31'b0, d1_valid_o[3]}, 32'h0);
      tick();
      chk("stall_send_after_credit", {31'b0, d1_valid_o[3]}, 32'h1);
      tick();
    end
    chk("stall_drain", exp_q[3].size(), 32'h0);
    d1_cr_man[3] = 1'b1;
    repeat (10) tick();
    d1_cr_man[3] = 1'b0;
    chk("credit_saturates_8", {28'b0, d1_cred[12 +: 4]}, 32'h8);
    auto_mask1[3] = 1'b1;

    // Corner router: head from L routed north (absent), S -> L stream continues.
    c0 = crd_cnt[9];
    c1 = crd_cnt[6];
    for (int k = 0; k < 6; k++) begin
      clr_in();
      f = mk(1, 1, 4'd2, 4'd2, 6'(k + 16));
      exp_q[9].push_back(f);
      put(1, 1, f);
      if (k == 0) begin d2_valid_i[4] = 1'b1; d2_data_i[4*DW +: DW] = mk(1, 0, 4'd0, 4'd2, 6'h3a); end
      if (k == 1) begin d2_valid_i[4] = 1'b1; d2_data_i[4*DW +: DW] = mk(0, 1, 4'd0, 4'd0, 6'h3b); end
      tick();
    end
    clr_in();
    repeat (8) tick();
    chk("corner_err_o", {31'b0, d2_err}, 32'h1);
    chk("corner_stream_drain", exp_q[9].size(), 32'h0);
    chk("corner_credit_o_S", crd_cnt[6] - c1, 32'd6);
`ifdef NOC_ROUTER_DROP_EN
    chk("corner_drop_credit_o_L", crd_cnt[9] - c0, 32'd2);
`else
    chk("corner_block_credit_o_L", crd_cnt[9] - c0, 32'd0);
`endif
    chk("full_err_o_clear", {31'b0, d1_err}, 32'h0);

    // Reset in the middle of a 4-flit S -> L packet.
    for (int k = 0; k < 2; k++) begin
      clr_in();
      f = mk(k == 0, 1'b0, 4'd2, 4'd2, 6'(k + 40));
      exp_q[4].push_back(f);
      put(0, 1, f);
      tick();
    end
    clr_in();
    tick();
    tick();
    chk("pre_reset_valid_L", {31'b0, d1_valid_o[4]}, 32'h1);
    @(negedge clk); #1;
    reset = 1'b0;
    #1;
    chk("midrst_valid_o", {27'b0, d1_valid_o}, 32'h0);
    chk("midrst_data_o", {31'b0, |d1_data_o}, 32'h0);
    chk("midrst_credit_o", {27'b0, d1_credit_o}, 32'h0);
    chk("midrst_drained", exp_q[4].size(), 32'h0);
    repeat (2) tick();
    reset = 1'b1;
    tick();
    chk("post_rst_credits", {12'b0, d1_cred}, {12'b0, CRED_FULL});
    chk("post_rst_unlocked", {27'b0, d1_lock}, 32'h0);
    chk("post_rst_corner_err", {31'b0, d2_err}, 32'h0);
    for (int k = 0; k < 2; k++) begin
      clr_in();
      f = mk(k == 0, k == 1, 4'd2, 4'd2, 6'(k + 48));
      exp_q[4].push_back(f);
      put(0, 2, f);
      tick();
    end
    clr_in();
    repeat (6) tick();
    chk("post_rst_route", exp_q[4].size(), 32'h0);

    // FIFO wrap: 20 back-to-back packets L -> S with immediate credit return.
    s0 = seen[1];
    max_run[1] = 0;
    for (int k = 0; k < 20; k++) begin
      clr_in();
      f = mk(1, 1, 4'd3, 4'd2, 6'(k));
      exp_q[1].push_back(f);
      put(0, 4, f);
      tick();
    end
    clr_in();
    repeat (8) tick();
    chk("wrap_count", seen[1] - s0, 32'd20);
    chk("wrap_no_gaps", max_run[1], 32'd20);
    chk("wrap_drain", exp_q[1].size(), 32'h0);
    chk("final_err_o", {31'b0, d1_err}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
